brownout_filt_nch: RTL and testbench
====================================

# brownout_filt_nch

Parametrised multi-channel digital back end for the brownout monitor. It takes NCH raw comparator outputs from the analog core, synchronises them, and applies per-channel programmable assert/release deglitch filters, which gives time-domain hysteresis. It also adds a startup blanking window, sticky trip flags and registered one-hot trip-tap decode. It sits on the dvdd domain between the comparators and the SoC, clocked by the on-chip RC oscillator.

## Interface
Parameters:
- NCH, 2: number of comparator channels (≥1).
- CNT_W, 8: width of filter counters and filter-length inputs.
- SYNC_STAGES, 2: synchroniser depth per channel (≥2).
- BLANK_CYC, 16: cycles after ena rises during which comparator inputs are ignored (0 = no blanking).

Ports:
- osc_ck  in  1  clock (RC oscillator output).
- resetb  in  1  reset; synchronous, active-low.
- ena  in  1  block enable.
- otrip  in  3  overvoltage/brownout trip tap select.
- vtrip  in  3  undervoltage trip tap select.
- cmp_in  in  NCH  raw asynchronous comparator outputs; 1 = supply below threshold.
- filt_set  in  CNT_W  consecutive high samples required to assert a channel.
- filt_clr  in  CNT_W  consecutive low samples required to release a channel.
- sticky_clr  in  1  clears sticky flags (level, sampled each cycle).
- otrip_decoded  out  8  registered one-hot of otrip.
- vtrip_decoded  out  8  registered one-hot of vtrip.
- brout_filt  out  NCH  filtered per-channel brownout state.
- out  out  1  OR of brout_filt.
- sticky  out  NCH  latched "channel has asserted" flags.
- ready  out  1  high in ACTIVE state.

## Operation
- Reset (resetb=0 at an edge): FSM=OFF; all counters, synchroniser flops, brout_filt, sticky, ready, otrip_decoded and vtrip_decoded are cleared to 0; out=0.
- Top FSM, OFF -> BLANK -> ACTIVE:
  - OFF: entered when ena=0.
  - OFF, ena=1: go to BLANK and load the blank counter with BLANK_CYC. If BLANK_CYC=0, go directly to ACTIVE.
  - BLANK: decrement each cycle; go to ACTIVE on the cycle the counter reaches 0.
  - Any state, ena=0: go to OFF next edge, clearing filter counters and brout_filt. sticky is retained.
- Decode: in BLANK and ACTIVE, otrip_decoded<=1<<otrip and vtrip_decoded<=1<<vtrip. In OFF both are 0.
- Synchroniser: SYNC_STAGES flops per channel run in every state. s[i] is the last stage.
- Per-channel filter (ACTIVE only; cnt held at 0 in OFF/BLANK). Effective length: Nset=max(filt_set,1), Nclr=max(filt_clr,1).
  - brout_filt=0, s=1: if cnt+1>=Nset, then brout_filt<=1 and cnt<=0; else cnt<=cnt+1.
  - brout_filt=0, s=0: cnt<=0.
  - brout_filt=1: mirror image using s=0 and Nclr.
  - Filter lengths are read live each cycle. If a lowered length is already met, the transition occurs on the next qualifying sample.
  - cnt cannot overflow because it never exceeds N-1.
- Sticky: sticky[i] sets on the cycle brout_filt[i] rises. sticky_clr=1 clears all flags, but a simultaneous set wins for that channel.
- out = |brout_filt, combinational from registers. ready = (state==ACTIVE), registered.

## Timing
- All outputs change only on rising osc_ck; no combinational input-to-output paths.
- Assert latency: cmp_in stable high before edge k, in ACTIVE, brout_filt=0. brout_filt rises after edge k+SYNC_STAGES+Nset-1, i.e. SYNC_STAGES+Nset edges. Release is symmetric with Nclr.
- High pulses shorter than Nset synchronised samples never assert; the counter restarts from 0.
- ena rise at edge e: ready=1 after edge e+BLANK_CYC (+1 if BLANK_CYC>0). Decodes are valid after edge e.
- ena fall: brout_filt, out, ready and decodes are 0 after the next edge.
- resetb low mid-count or mid-blank: everything is cleared at that edge. After release the block starts in OFF, and a new ena rise is required if ena was held high.

## Test plan
- Reset: drive resetb=0 with ena=1 and cmp_in all high for 3 cycles -> all outputs 0. After release with ena=1, ready=1 exactly 17 edges later (BLANK_CYC=16); brout_filt stays 0 through blanking.
- Assert/release latency (SYNC_STAGES=2, filt_set=4, filt_clr=6): step cmp_in[0] high -> brout_filt[0]=1 and out=1 after 6 edges, sticky[0]=1 in the same cycle. Step low -> release after 8 edges; sticky[0] remains 1.
- Glitch rejection: 3-cycle high pulse on cmp_in[1] with filt_set=4 -> brout_filt[1] never rises. A following 4-cycle pulse asserts it.
- Sticky clear collision: hold sticky_clr=1 on the same edge brout_filt[0] rises -> sticky[0]=1, while the other set flags clear.
- Decode and disable: otrip=5, vtrip=2 in ACTIVE -> otrip_decoded=8'h20, vtrip_decoded=8'h04. Drop ena mid-count -> decodes, brout_filt and ready go to 0 next edge, and sticky is retained.
- filt_set=0: a single synchronised high sample asserts (treated as 1), giving 3-edge latency with SYNC_STAGES=2.

Source files
------------

// File: rtl/brownout_filt_nch_if.sv
// Bundle of the brownout back end's control inputs and status outputs.
// The slave modport is the block's view; the master modport is the driving side.
interface brownout_filt_nch_if #(
   parameter int NCH   = 2,
   parameter int CNT_W = 8
);
   logic             ena;
   logic [2:0]       otrip;
   logic [2:0]       vtrip;
   logic [NCH-1:0]   cmp_in;
   logic [CNT_W-1:0] filt_set;
   logic [CNT_W-1:0] filt_clr;
   logic             sticky_clr;
   logic [7:0]       otrip_decoded;
   logic [7:0]       vtrip_decoded;
   logic [NCH-1:0]   brout_filt;
   logic             out;
   logic [NCH-1:0]   sticky;
   logic             ready;

   modport master (
      output ena, otrip, vtrip, cmp_in, filt_set, filt_clr, sticky_clr,
      input  otrip_decoded, vtrip_decoded, brout_filt, out, sticky, ready
   );

   modport slave (
      input  ena, otrip, vtrip, cmp_in, filt_set, filt_clr, sticky_clr,
      output otrip_decoded, vtrip_decoded, brout_filt, out, sticky, ready
   );
endinterface

// File: rtl/brownout_filt_nch.sv
// Brownout back end: per-channel synchronisers, assert/release deglitch filters,
// startup blanking, sticky trip flags and registered one-hot trip-tap decodes.
module brownout_filt_nch #(
   parameter int NCH         = 2,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int BLANK_CYC   = 16
) (
   input logic                osc_ck,
   input logic                resetb,
   brownout_filt_nch_if.slave bus
);

   localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
   localparam logic [CNT_W:0] ONE_W = 1;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [BW-1:0]          blank_q, blank_d;
   logic [SYNC_STAGES-1:0] sync_q [NCH];
   logic [NCH-1:0]         s;
   logic [CNT_W-1:0]       cnt_q [NCH];
   logic [CNT_W-1:0]       cnt_d [NCH];
   logic [CNT_W-1:0]       nSet, nClr;
   logic [NCH-1:0]         brout_q, brout_d;
   logic [NCH-1:0]         sticky_q, sticky_d;
   logic                   ready_q, ready_d;
   logic [7:0]             odec_q, odec_d;
   logic [7:0]             vdec_q, vdec_d;

   always_ff @(posedge osc_ck) begin
      if (!resetb) begin
         state_q <= OFF;
         blank_q <= '0;
      end else begin
         state_q <= state_d;
         blank_q <= blank_d;
      end
   end

   // The blank counter sits at zero for one full cycle before ACTIVE is entered.
   always_comb begin
      state_d = state_q;
      blank_d = blank_q;
      if (!bus.ena) begin
         state_d = OFF;
         blank_d = '0;
      end else begin
         case (state_q)
            OFF: begin
               if (BLANK_CYC == 0) begin
                  state_d = ACTIVE;
               end else begin
                  state_d = BLANK;
                  blank_d = BW'(BLANK_CYC);
               end
            end
            BLANK: begin
               if (blank_q == '0) begin
                  state_d = ACTIVE;
               end else begin
                  blank_d = blank_q - BW'(1);
               end
            end
            ACTIVE:  state_d = ACTIVE;
            default: state_d = OFF;
         endcase
      end
   end

   always_comb begin
      ready_d = (state_d == ACTIVE);
      odec_d  = (state_d != OFF) ? (8'd1 << bus.otrip) : 8'd0;
      vdec_d  = (state_d != OFF) ? (8'd1 << bus.vtrip) : 8'd0;
   end

   always_ff @(posedge osc_ck) begin
      for (int i = 0; i < NCH; i++) begin
         if (!resetb) begin
            sync_q[i] <= '0;
         end else begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.cmp_in[i]};
         end
      end
   end

   // A zero filter length behaves as one so a single sample can still switch a channel.
   always_comb begin
      nSet = (bus.filt_set == '0) ? CNT_W'(1) : bus.filt_set;
      nClr = (bus.filt_clr == '0) ? CNT_W'(1) : bus.filt_clr;
      for (int i = 0; i < NCH; i++) begin
         s[i]       = sync_q[i][SYNC_STAGES-1];
         cnt_d[i]   = '0;
         brout_d[i] = brout_q[i];
         if (state_q == ACTIVE && bus.ena) begin
            if (s[i] != brout_q[i]) begin
               if (({1'b0, cnt_q[i]} + ONE_W) >= {1'b0, (brout_q[i] ? nClr : nSet)}) begin
                  brout_d[i] = ~brout_q[i];
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
         end else begin
            brout_d[i] = 1'b0;
         end
      end
      sticky_d = (bus.sticky_clr ? '0 : sticky_q) | (brout_d & ~brout_q);
   end

   always_ff @(posedge osc_ck) begin
      if (!resetb) begin
         brout_q  <= '0;
         sticky_q <= '0;
         ready_q  <= 1'b0;
         odec_q   <= '0;
         vdec_q   <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         brout_q  <= brout_d;
         sticky_q <= sticky_d;
         ready_q  <= ready_d;
         odec_q   <= odec_d;
         vdec_q   <= vdec_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.brout_filt    = brout_q;
   assign bus.out           = |brout_q;
   assign bus.sticky        = sticky_q;
   assign bus.ready         = ready_q;
   assign bus.otrip_decoded = odec_q;
   assign bus.vtrip_decoded = vdec_q;

endmodule

// File: tb/tb_brownout_filt_nch.sv
// Bench for brownout_filt_nch: directed scenarios with literal expectations,
// then randomized traffic, all checked each cycle against a behavioural model.
module tb_brownout_filt_nch;

   localparam int NCH    = 2;
   localparam int CNT_W  = 8;
   localparam int SYNC   = 2;
   localparam int BLANK  = 16;
   localparam int ACT_AT = (BLANK == 0) ? 0 : BLANK + 1;

   logic osc_ck = 1'b0;
   logic resetb;
   int   total = 0;
   int   bad   = 0;

   brownout_filt_nch_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

   brownout_filt_nch #(
      .NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .BLANK_CYC(BLANK)
   ) dut (
      .osc_ck(osc_ck),
      .resetb(resetb),
      .bus(bus.slave)
   );

   always #5 osc_ck = ~osc_ck;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: comparator samples arrive SYNC edges late; a channel flips once it has
   // seen N consecutive samples disagreeing with its current state.
   logic [NCH-1:0] mDly [SYNC];
   logic [NCH-1:0] mFilt, mSticky;
   int             mRun [NCH];
   bit             mOn;
   int             mAge;
   logic [7:0]     mOdec, mVdec;
   bit             mReady;
   bit             mValid = 1'b0;

   task automatic modelStep();
      logic [NCH-1:0] sNow, newFilt;
      bit             wasActive;
      int             nLen;
      if (resetb !== 1'b1) begin
         for (int k = 0; k < SYNC; k++) mDly[k] = '0;
         for (int ch = 0; ch < NCH; ch++) mRun[ch] = 0;
         mFilt   = '0;
         mSticky = '0;
         mOn     = 1'b0;
         mAge    = 0;
         mOdec   = '0;
         mVdec   = '0;
      end else begin
         sNow = mDly[SYNC-1];
         for (int k = SYNC - 1; k > 0; k--) mDly[k] = mDly[k-1];
         mDly[0]   = bus.cmp_in;
         wasActive = mOn && (mAge >= ACT_AT);
         newFilt   = mFilt;
         for (int ch = 0; ch < NCH; ch++) begin
            if (bus.ena && wasActive) begin
               nLen = mFilt[ch] ? int'(bus.filt_clr) : int'(bus.filt_set);
               if (nLen < 1) nLen = 1;
               if (sNow[ch] != mFilt[ch]) begin
                  mRun[ch]++;
                  if (mRun[ch] >= nLen) begin
                     newFilt[ch] = ~mFilt[ch];
                     mRun[ch]    = 0;
                  end
               end else begin
                  mRun[ch] = 0;
               end
            end else begin
               newFilt[ch] = 1'b0;
               mRun[ch]    = 0;
            end
         end
         mSticky = (bus.sticky_clr ? '0 : mSticky) | (newFilt & ~mFilt);
         mFilt   = newFilt;
         if (!bus.ena) begin
            mOn   = 1'b0;
            mAge  = 0;
            mOdec = '0;
            mVdec = '0;
         end else begin
            if (mOn) begin
               if (mAge < 1000000) mAge++;
            end else begin
               mOn  = 1'b1;
               mAge = 0;
            end
            mOdec = 8'd1 << bus.otrip;
            mVdec = 8'd1 << bus.vtrip;
         end
      end
      mReady = mOn && (mAge >= ACT_AT);
      mValid = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge osc_ck);
         modelStep();
      end
   end

   initial begin
      forever begin
         @(negedge osc_ck);
         if (mValid) begin
            checkOutput("brout_filt vs model", bus.brout_filt, mFilt);
            checkOutput("out vs model", bus.out, |mFilt);
            checkOutput("sticky vs model", bus.sticky, mSticky);
            checkOutput("ready vs model", bus.ready, mReady);
            checkOutput("otrip_decoded vs model", bus.otrip_decoded, mOdec);
            checkOutput("vtrip_decoded vs model", bus.vtrip_decoded, mVdec);
         end
      end
   end

   task automatic countEdges(input int ch, input logic val, input int maxN, output int n);
      n = 0;
      do begin
         @(negedge osc_ck);
         n++;
      end while (bus.brout_filt[ch] !== val && n < maxN);
   endtask

   task automatic applyStimulus();
      int n;
      bit flag;

      resetb         = 1'b0;
      bus.ena        = 1'b1;
      bus.cmp_in     = '1;
      bus.filt_set   = 8'd4;
      bus.filt_clr   = 8'd6;
      bus.sticky_clr = 1'b0;
      bus.otrip      = 3'd0;
      bus.vtrip      = 3'd0;
      repeat (3) @(negedge osc_ck);
      checkOutput("reset ready", bus.ready, 0);
      checkOutput("reset brout_filt", bus.brout_filt, 0);
      checkOutput("reset out", bus.out, 0);
      checkOutput("reset sticky", bus.sticky, 0);
      checkOutput("reset otrip_decoded", bus.otrip_decoded, 0);
      checkOutput("reset vtrip_decoded", bus.vtrip_decoded, 0);

      resetb = 1'b1;
      n = 0;
      flag = 1'b0;
      do begin
         @(negedge osc_ck);
         n++;
         if (bus.brout_filt != '0) flag = 1'b1;
      end while (bus.ready !== 1'b1 && n < 60);
      checkOutput("ready edges after enable edge", n - 1, 17);
      checkOutput("brout_filt during blanking", flag, 0);

      bus.cmp_in = '0;
      repeat (6) @(negedge osc_ck);
      bus.cmp_in[0] = 1'b1;
      countEdges(0, 1'b1, 20, n);
      checkOutput("assert latency", n, 6);
      checkOutput("sticky0 on assert", bus.sticky[0], 1);
      checkOutput("out on assert", bus.out, 1);
      bus.cmp_in[0] = 1'b0;
      countEdges(0, 1'b0, 20, n);
      checkOutput("release latency", n, 8);
      checkOutput("sticky0 after release", bus.sticky[0], 1);

      bus.cmp_in[1] = 1'b1;
      repeat (3) @(negedge osc_ck);
      bus.cmp_in[1] = 1'b0;
      flag = 1'b0;
      repeat (12) begin
         @(negedge osc_ck);
         if (bus.brout_filt[1]) flag = 1'b1;
      end
      checkOutput("3-cycle glitch rejected", flag, 0);
      bus.cmp_in[1] = 1'b1;
      repeat (4) @(negedge osc_ck);
      bus.cmp_in[1] = 1'b0;
      flag = 1'b0;
      repeat (12) begin
         @(negedge osc_ck);
         if (bus.brout_filt[1]) flag = 1'b1;
      end
      checkOutput("4-cycle pulse asserts", flag, 1);

      repeat (20) @(negedge osc_ck);
      bus.sticky_clr = 1'b1;
      @(negedge osc_ck);
      bus.sticky_clr = 1'b0;
      checkOutput("sticky cleared", bus.sticky, 0);
      bus.cmp_in[1] = 1'b1;
      repeat (10) @(negedge osc_ck);
      checkOutput("ch1 held asserted", bus.brout_filt, 2'b10);
      bus.cmp_in[0] = 1'b1;
      repeat (5) @(negedge osc_ck);
      bus.sticky_clr = 1'b1;
      @(negedge osc_ck);
      bus.sticky_clr = 1'b0;
      checkOutput("collision brout_filt", bus.brout_filt, 2'b11);
      checkOutput("collision sticky", bus.sticky, 2'b01);

      bus.otrip = 3'd5;
      bus.vtrip = 3'd2;
      @(negedge osc_ck);
      checkOutput("otrip_decoded 5", bus.otrip_decoded, 8'h20);
      checkOutput("vtrip_decoded 2", bus.vtrip_decoded, 8'h04);
      bus.cmp_in[0] = 1'b0;
      repeat (2) @(negedge osc_ck);
      bus.ena = 1'b0;
      @(negedge osc_ck);
      checkOutput("disable otrip_decoded", bus.otrip_decoded, 0);
      checkOutput("disable vtrip_decoded", bus.vtrip_decoded, 0);
      checkOutput("disable brout_filt", bus.brout_filt, 0);
      checkOutput("disable out", bus.out, 0);
      checkOutput("disable ready", bus.ready, 0);
      checkOutput("disable sticky retained", bus.sticky, 2'b01);

      bus.filt_set = 8'd0;
      bus.cmp_in   = '0;
      bus.ena      = 1'b1;
      n = 0;
      do begin
         @(negedge osc_ck);
         n++;
      end while (bus.ready !== 1'b1 && n < 60);
      checkOutput("ready after re-enable", bus.ready, 1);
      repeat (4) @(negedge osc_ck);
      bus.cmp_in[0] = 1'b1;
      countEdges(0, 1'b1, 20, n);
      checkOutput("filt_set=0 latency", n, 3);

      for (int c = 0; c < 4000; c++) begin
         @(negedge osc_ck);
         resetb = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 79) == 0) bus.ena = ~bus.ena;
         for (int ch = 0; ch < NCH; ch++) begin
            if ($urandom_range(0, 3) == 0) bus.cmp_in[ch] = ~bus.cmp_in[ch];
         end
         if ($urandom_range(0, 49) == 0) bus.filt_set = CNT_W'($urandom_range(0, 6));
         if ($urandom_range(0, 49) == 0) bus.filt_clr = CNT_W'($urandom_range(0, 6));
         bus.sticky_clr = ($urandom_range(0, 19) == 0);
         bus.otrip      = 3'($urandom_range(0, 7));
         bus.vtrip      = 3'($urandom_range(0, 7));
      end
      repeat (3) @(negedge osc_ck);
   endtask

   initial begin
      applyStimulus();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
